seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder: monitors a time-multiplexed 7-segment display bus (segment lines, dot and one-hot digit enables), waits for each digit's pattern to settle and maps the pattern back to a hex nibble.
- Assembles one nibble per digit into a frame and presents it on a valid/ready output.
- Used for display loopback self-test and for snooping external display drivers.

Parameters:
NDIG, 4, number of multiplexed digits (>=2).
STABLE_CYC, 4, consecutive identical samples required before a digit is captured (>=1).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
seg  input  7  segment lines {a,b,c,d,e,f,g}; a = seg[6], g = seg[0]; active-high.
dp  input  1  dot segment, active-high.
dig_en  input  NDIG  digit enables, active-high, expected one-hot or all-zero (blanking).
frame_data  output  4*NDIG  digit k nibble at [4k+3:4k]; digit 0 least significant.
frame_dp  output  NDIG  captured dot per digit.
frame_err  output  NDIG  1 = pattern for that digit was not a legal glyph.
frame_valid  output  1  frame available.
frame_ready  input  1  consumer accepts the frame when frame_valid && frame_ready.
sync_err  output  1  one-cycle pulse on a scan-order violation.
overflow  output  1  sticky; set when a completed frame is dropped. Cleared only by reset.

Behaviour:
- Reset values: all outputs 0; FSM in HUNT; sample registers 0; stability counter 0.
- Input stage: seg, dp and dig_en are registered once (s_seg, s_dp, s_en). All decisions use the registered values.
- Stability counter:
  - Loads 1 when {s_seg, s_dp, s_en} differs from the previous cycle's value; otherwise increments, saturating at STABLE_CYC.
  - A capture event occurs on the cycle the counter reaches STABLE_CYC, with s_en one-hot. At most one capture per dwell.
- Glyph map (seg hex -> nibble): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F.
  - Any other pattern gives nibble 0 with the err bit set.
  - dp is stored as-is.
- FSM states:
  - HUNT: wait for a capture with s_en[0]. On capture, store digit 0 (nibble, dp, err); next = 1; go to SCAN.
  - SCAN:
    - All-zero s_en is ignored.
    - A capture with s_en = bit[next] stores that digit. If next == NDIG-1, go to PUBLISH; else next++.
    - A capture or one-hot s_en on any other bit, or s_en with more than one bit set, is a violation: pulse sync_err, discard the partial frame, go to HUNT.
    - An s_en[0] violation may not itself start the new frame; HUNT requires a fresh capture.
  - PUBLISH (1 cycle): if the output register is free (frame_valid == 0), or is freed this cycle by a handshake, load frame_data/frame_dp/frame_err and set frame_valid. Otherwise drop the frame and set overflow. Always return to HUNT.
- Latency: frame_valid rises the cycle after the last digit's capture cycle.
- Output handshake:
  - frame_data, frame_dp and frame_err are stable while frame_valid && !frame_ready.
  - frame_valid clears the cycle after the handshake unless PUBLISH reloads in that same cycle. A simultaneous handshake and PUBLISH keeps frame_valid high with the new data.
- Scanning continues while a frame is held; only the PUBLISH step is affected by backpressure.
- Asynchronous reset mid-frame: everything returns to reset values immediately. No partial frame is ever presented.
- Counter width: clog2(STABLE_CYC+1). The next-digit index is clog2(NDIG) wide.

Test Plan:
- NDIG=4, STABLE_CYC=4; scan digits 0..3 with patterns 47,79,77,30, 8 cycles each, 2 blank cycles between, frame_ready=1 -> frame_data=16'h1A3F, frame_err=0, frame_valid for 1 cycle, one cycle after digit 3 capture.
- Same scan, digit 2 pattern 7'h00 and dp=1 on digit 1 -> frame_data=16'h103F, frame_err=4'b0100, frame_dp=4'b0010.
- Digit 1 dwell of 3 cycles, then re-driven correctly for 8 cycles -> only the 8-cycle dwell is captured, no sync_err, correct frame.
- Order 0,2 -> sync_err pulses once, no frame. A following full 0..3 scan yields a correct frame.
- frame_ready=0; two complete frames -> first frame held unchanged, overflow=1 after the second. Then frame_ready=1 -> frame_valid drops the next cycle and overflow stays 1.
- rst_n low during digit 2 of a frame -> all outputs 0 immediately. After release, a full scan produces a correct frame with no stale digits.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed 7-segment display bus: waits for each digit's
// pattern to settle, decodes it back to a hex nibble and publishes whole frames.
module seg7_scan_reader #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           seg,
    input  logic                 dp,
    input  logic [NDIG-1:0]      dig_en,
    output logic [4*NDIG-1:0]    frame_data,
    output logic [NDIG-1:0]      frame_dp,
    output logic [NDIG-1:0]      frame_err,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 sync_err,
    output logic                 overflow
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

    typedef enum logic [1:0] {
        HUNT,
        SCAN,
        PUBLISH
    } state_t;

    state_t            state;
    logic [6:0]        s_seg, p_seg;
    logic              s_dp, p_dp;
    logic [NDIG-1:0]   s_en, p_en;
    logic [CW-1:0]     cnt, cnt_cur;
    logic [IW-1:0]     nxt;
    logic [4*NDIG-1:0] buf_data;
    logic [NDIG-1:0]   buf_dp, buf_err;
    logic              block;

    logic              changed, capture;
    logic              en_zero, en_onehot, en_multi, violation;
    logic [NDIG-1:0]   next_bit, prev_bit;
    logic [3:0]        nib;
    logic              glyph_err;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_dp  <= 1'b0;
            s_en  <= '0;
            p_seg <= '0;
            p_dp  <= 1'b0;
            p_en  <= '0;
            cnt   <= '0;
        end else begin
            s_seg <= seg;
            s_dp  <= dp;
            s_en  <= dig_en;
            p_seg <= s_seg;
            p_dp  <= s_dp;
            p_en  <= s_en;
            cnt   <= cnt_cur;
        end
    end

    assign changed = {s_seg, s_dp, s_en} != {p_seg, p_dp, p_en};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_cur = cnt;
        if (changed)
            cnt_cur = CW'(1);
        else if (cnt != CNT_MAX)
            cnt_cur = cnt + CW'(1);
    end

    // The "changed" term re-arms the capture when STABLE_CYC is 1 and the counter never leaves 1.
    assign capture   = (cnt_cur == CNT_MAX) && (changed || (cnt != CNT_MAX));

    assign en_zero   = (s_en == '0);
    assign en_onehot = !en_zero && ((s_en & (s_en - NDIG'(1))) == '0);
    assign en_multi  = !en_zero && !en_onehot;
    assign next_bit  = NDIG'(1) << nxt;
    assign prev_bit  = NDIG'(1) << (nxt - IW'(1));

    // The digit just captured keeps its enable for the rest of its dwell, so it is not a violation.
    assign violation = en_multi
                    || (en_onehot && (s_en != next_bit) && (s_en != prev_bit))
                    || (capture && en_onehot && (s_en != next_bit));

    always_comb begin
        nib       = 4'h0;
        glyph_err = 1'b0;
        case (s_seg)
            7'h7E:   nib = 4'h0;
            7'h30:   nib = 4'h1;
            7'h6D:   nib = 4'h2;
            7'h79:   nib = 4'h3;
            7'h33:   nib = 4'h4;
            7'h5B:   nib = 4'h5;
            7'h5F:   nib = 4'h6;
            7'h70:   nib = 4'h7;
            7'h7F:   nib = 4'h8;
            7'h7B:   nib = 4'h9;
            7'h77:   nib = 4'hA;
            7'h1F:   nib = 4'hB;
            7'h4E:   nib = 4'hC;
            7'h3D:   nib = 4'hD;
            7'h4F:   nib = 4'hE;
            7'h47:   nib = 4'hF;
            default: glyph_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            nxt         <= '0;
            buf_data    <= '0;
            buf_dp      <= '0;
            buf_err     <= '0;
            block       <= 1'b0;
            frame_data  <= '0;
            frame_dp    <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (frame_valid && frame_ready)
                frame_valid <= 1'b0;

            // A dwell that caused a violation must not also open the next frame.
            if (state == SCAN && violation)
                block <= 1'b1;
            else if (changed)
                block <= 1'b0;

            case (state)
                HUNT: begin
                    if (capture && (s_en == NDIG'(1)) && !block) begin
                        buf_data[3:0] <= nib;
                        buf_dp[0]     <= s_dp;
                        buf_err[0]    <= glyph_err;
                        nxt           <= IW'(1);
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (violation) begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                    end else if (capture && (s_en == next_bit)) begin
                        buf_data[4*int'(nxt) +: 4] <= nib;
                        buf_dp[nxt]                <= s_dp;
                        buf_err[nxt]               <= glyph_err;
                        if (nxt == IW'(NDIG - 1))
                            state <= PUBLISH;
                        else
                            nxt <= nxt + IW'(1);
                    end
                end
                PUBLISH: begin
                    if (!frame_valid || frame_ready) begin
                        frame_data  <= buf_data;
                        frame_dp    <= buf_dp;
                        frame_err   <= buf_err;
                        frame_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                    state <= HUNT;
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: table-driven glyph frames, directed
// corner sequences and a randomized dwell stream against a dwell-level model.
module tb_seg7_scan_reader;

    localparam int NDIG = 4;
    localparam int SC   = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        seg = '0;
    logic              dp = 1'b0;
    logic [NDIG-1:0]   dig_en = '0;
    logic              frame_ready = 1'b1;
    logic [4*NDIG-1:0] frame_data;
    logic [NDIG-1:0]   frame_dp, frame_err;
    logic              frame_valid, sync_err, overflow;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .dig_en(dig_en),
        .frame_data(frame_data), .frame_dp(frame_dp), .frame_err(frame_err),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .sync_err(sync_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sync_cnt = 0;
    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    bit          hold = 0;
    logic [23:0] held;

    typedef struct {
        logic [6:0] pat;
        logic       dp;
        logic [3:0] nib;
        logic       err;
    } vec_t;
    vec_t tbl[20];

    bit          m_scan = 0;
    int          m_next = 0;
    int          m_sync = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0, m_err = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame records are {err[3:0], dp[3:0], data[15:0]}; sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 0;
        end else begin
            if (hold) begin
                check("held frame_valid", frame_valid, 1'b1);
                check("held frame contents", {frame_err, frame_dp, frame_data}, held);
            end
            if (frame_valid && frame_ready)
                got_q.push_back({frame_err, frame_dp, frame_data});
            if (sync_err)
                sync_cnt++;
            hold = frame_valid && !frame_ready;
            held = {frame_err, frame_dp, frame_data};
        end
    end

    function automatic logic [NDIG-1:0] oh(input int d);
        return NDIG'(1) << d;
    endfunction

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (GLYPH[i] == p) return {1'b0, 4'(i)};
        return 5'b1_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [NDIG-1:0] en, input logic [6:0] pat, input logic dpv, input int n);
        dig_en = en;
        seg    = pat;
        dp     = dpv;
        repeat (n) tick();
    endtask

    task automatic blank(input int n);
        show('0, 7'h00, 1'b0, n);
    endtask

    task automatic scan_frame(input logic [27:0] pats, input logic [3:0] dps);
        for (int k = 0; k < NDIG; k++) begin
            show(oh(k), pats[7*k +: 7], dps[k], 8);
            blank(2);
        end
    endtask

    task automatic expect_frame(input string name, input logic [23:0] e);
        check({name, " frame count"}, got_q.size(), 1);
        if (got_q.size() > 0)
            check(name, got_q.pop_front(), e);
        got_q.delete();
    endtask

    task automatic store(input int i, input logic [6:0] pat, input logic dpv);
        logic [4:0] d;
        d = ref_decode(pat);
        m_data[4*i +: 4] = d[3:0];
        m_err[i]         = d[4];
        m_dp[i]          = dpv;
    endtask

    // Dwell-level model: each dwell is separated by blanking, so it is captured iff it lasts >= SC cycles.
    task automatic model_dwell(input logic [NDIG-1:0] en, input logic [6:0] pat, input logic dpv, input int len);
        int ones;
        bit cap;
        ones = $countones(en);
        cap  = (len >= SC) && (ones == 1);
        if (!m_scan) begin
            if (cap && en == oh(0)) begin
                store(0, pat, dpv);
                m_next = 1;
                m_scan = 1;
            end
        end else if (ones > 1 || (ones == 1 && en != oh(m_next) && en != oh(m_next - 1))
                     || (cap && en != oh(m_next))) begin
            m_sync++;
            m_scan = 0;
        end else if (cap) begin
            store(m_next, pat, dpv);
            if (m_next == NDIG - 1) begin
                exp_q.push_back({m_err, m_dp, m_data});
                m_scan = 0;
            end else begin
                m_next++;
            end
        end
    endtask

    task automatic run_random(input int ndwell);
        int k, r, a, b, len, s0;
        logic [NDIG-1:0] en;
        logic [6:0] pat;
        logic dpv;
        k  = 0;
        s0 = sync_cnt;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < ndwell; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                en = oh(k);
                k  = (k + 1) % NDIG;
            end else if (r < 90) begin
                en = oh($urandom_range(0, NDIG - 1));
            end else begin
                a  = $urandom_range(0, NDIG - 1);
                b  = (a + 1 + $urandom_range(0, NDIG - 2)) % NDIG;
                en = oh(a) | oh(b);
            end
            len = ($urandom_range(0, 99) < 80) ? $urandom_range(SC, 8) : $urandom_range(1, SC - 1);
            pat = ($urandom_range(0, 99) < 85) ? GLYPH[$urandom_range(0, 15)] : 7'($urandom);
            dpv = 1'($urandom);
            blank(2);
            show(en, pat, dpv, len);
            model_dwell(en, pat, dpv, len);
        end
        blank(4);
        check("random sync_err pulses", sync_cnt - s0, m_sync);
        check("random frame count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check("random frame", got_q.pop_front(), exp_q.pop_front());
        check("random overflow", overflow, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, s0;
        for (int i = 0; i < 16; i++)
            tbl[i] = '{GLYPH[i], 1'(i % 2), 4'(i), 1'b0};
        tbl[16] = '{7'h00, 1'b1, 4'h0, 1'b1};
        tbl[17] = '{7'h01, 1'b0, 4'h0, 1'b1};
        tbl[18] = '{7'h7D, 1'b1, 4'h0, 1'b1};
        tbl[19] = '{7'h3F, 1'b0, 4'h0, 1'b1};

        repeat (3) tick();
        check("reset frame_valid", frame_valid, 1'b0);
        check("reset frame_data", frame_data, 16'h0);
        check("reset frame_dp/err", {frame_dp, frame_err}, 8'h0);
        check("reset sync_err/overflow", {sync_err, overflow}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Basic scan 0..3 with latency: input change -> 4 registered samples -> counter hits 4 -> PUBLISH.
        for (int k = 0; k < 3; k++) begin
            show(oh(k), (k == 0) ? 7'h47 : (k == 1) ? 7'h79 : 7'h77, 1'b0, 8);
            blank(2);
        end
        dig_en = oh(3);
        seg    = 7'h30;
        lat    = 0;
        while (!frame_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("basic latency", lat, 6);
        check("basic frame_data", frame_data, 16'h1A3F);
        check("basic frame_err", frame_err, 4'b0000);
        tick();
        check("basic frame_valid one cycle", frame_valid, 1'b0);
        blank(2);
        expect_frame("basic frame", {4'h0, 4'h0, 16'h1A3F});

        // Illegal glyph on digit 2 and dot on digit 1.
        scan_frame({7'h30, 7'h00, 7'h79, 7'h47}, 4'b0010);
        expect_frame("illegal glyph frame", {4'b0100, 4'b0010, 16'h103F});
        check("no sync_err so far", sync_cnt, 0);

        // Short dwell on digit 1 is not captured; the later full dwell is.
        show(oh(0), 7'h47, 1'b0, 8); blank(2);
        show(oh(1), 7'h7E, 1'b0, 3); blank(2);
        show(oh(1), 7'h79, 1'b0, 8); blank(2);
        show(oh(2), 7'h77, 1'b0, 8); blank(2);
        show(oh(3), 7'h30, 1'b0, 8); blank(2);
        expect_frame("short dwell frame", {4'h0, 4'h0, 16'h1A3F});
        check("short dwell sync_err", sync_cnt, 0);

        // Out-of-order scan 0,2.
        s0 = sync_cnt;
        show(oh(0), 7'h47, 1'b0, 8); blank(2);
        show(oh(2), 7'h77, 1'b0, 8); blank(2);
        check("order violation sync_err pulses", sync_cnt - s0, 1);
        check("order violation no frame", got_q.size(), 0);
        scan_frame({7'h30, 7'h77, 7'h79, 7'h47}, 4'b0000);
        expect_frame("recovery frame", {4'h0, 4'h0, 16'h1A3F});

        // Table-driven glyph vectors, four per frame.
        for (int g = 0; g < 5; g++) begin
            logic [27:0] pats;
            logic [3:0]  dps;
            logic [23:0] e;
            for (int k = 0; k < NDIG; k++) begin
                pats[7*k +: 7]  = tbl[4*g + k].pat;
                dps[k]          = tbl[4*g + k].dp;
                e[4*k +: 4]     = tbl[4*g + k].nib;
                e[16 + k]       = tbl[4*g + k].dp;
                e[20 + k]       = tbl[4*g + k].err;
            end
            scan_frame(pats, dps);
            expect_frame($sformatf("table group %0d", g), e);
        end

        // Backpressure: second frame dropped, first held.
        frame_ready = 1'b0;
        scan_frame({7'h30, 7'h77, 7'h79, 7'h47}, 4'b0000);
        scan_frame({7'h79, 7'h6D, 7'h30, 7'h7E}, 4'b1111);
        check("backpressure frame_valid", frame_valid, 1'b1);
        check("backpressure held data", {frame_err, frame_dp, frame_data}, {4'h0, 4'h0, 16'h1A3F});
        check("backpressure overflow", overflow, 1'b1);
        check("backpressure no handshake", got_q.size(), 0);
        frame_ready = 1'b1;
        tick();
        check("release frame_valid drop", frame_valid, 1'b0);
        check("release overflow sticky", overflow, 1'b1);
        expect_frame("released frame", {4'h0, 4'h0, 16'h1A3F});

        // Asynchronous reset during digit 2.
        show(oh(0), 7'h47, 1'b0, 8); blank(2);
        show(oh(1), 7'h79, 1'b0, 8); blank(2);
        show(oh(2), 7'h77, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check("async reset frame_valid", frame_valid, 1'b0);
        check("async reset frame_data", frame_data, 16'h0);
        check("async reset dp/err", {frame_dp, frame_err}, 8'h0);
        check("async reset overflow/sync", {overflow, sync_err}, 2'b00);
        blank(2);
        rst_n = 1'b1;
        blank(2);
        got_q.delete();
        scan_frame({7'h4F, 7'h3D, 7'h4E, 7'h1F}, 4'b0000);
        expect_frame("post-reset frame", {4'h0, 4'h0, 16'hEDCB});

        run_random(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
